// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM states, NOP encoding, default PC step
// and the load opcode also used by the ID-stage hazard detector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam int          PC_STEP_DEFAULT = 4;
  localparam logic [6:0]  LOAD_OPCODE     = 7'b0000011;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with increment enable and asynchronous active-high reset.
// Holds at all-ones once reached so long-running event counts never wrap to zero.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline control responder: owns the PC, turns load-use stalls and EX redirects into
// hold/flush/bubble controls. Performance counters are built only with PIPE_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PCdelay,
  input  logic            Mwk,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] PC,
  output logic            IF_ID_hold,
  output logic            IF_ID_flush,
  output logic            ID_EX_bubble,
  output logic            clear
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  ctrl_state_t     state;
  ctrl_state_t     next_state;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_seq;

  assign pc_seq = PC + XLEN'(PC_STEP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      PC    <= RESET_PC;
    end else begin
      state <= next_state;
      PC    <= pc_next;
    end
  end

  // Redirect beats stall; a stall is only honoured from RUN so one bubble per load.
  always_comb begin
    next_state = RUN;
    pc_next    = pc_seq;
    IF_ID_hold = 1'b0;
    if (branch_taken) begin
      next_state = FLUSH;
      pc_next    = branch_target;
    end else if (PCdelay && (state == RUN)) begin
      next_state = STALL;
      pc_next    = PC;
      IF_ID_hold = 1'b1;
    end
  end

  assign ID_EX_bubble = (state == STALL) || (state == FLUSH);
  assign IF_ID_flush  = (state == FLUSH);
  assign clear        = (state == FLUSH) || RST;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // Stalls count only for a valid ID instruction; every accepted redirect counts.
  assign stall_inc = (state == RUN) && (next_state == STALL) && Mwk;
  assign flush_inc = branch_taken;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  logic mwk_unused;
  assign mwk_unused = Mwk;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expected per-cycle outputs are queued when
// stimulus is driven and compared shortly before the following rising edge.
module tb_pipe_stall_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic        hold;
    logic        bubble;
    logic        flush;
    logic        clr;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCdelay = 1'b0;
  logic        Mwk = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] PC;
  logic        IF_ID_hold;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        clear;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  pipe_stall_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .PCdelay       (PCdelay),
    .Mwk           (Mwk),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .PC            (PC),
    .IF_ID_hold    (IF_ID_hold),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EX_bubble  (ID_EX_bubble),
    .clear         (clear)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
  endtask

  // Drive one cycle at the falling edge and queue what the DUT must show before the next rise.
  task automatic applyStimulus(input logic rst, input logic pcd, input logic mwk, input logic bt,
                               input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_hold,
                               input logic e_bub, input logic e_flush, input logic e_clr,
                               input logic [31:0] e_sc, input logic [31:0] e_fc);
    exp_t e;
    @(negedge CLK);
    RST           = rst;
    PCdelay       = pcd;
    Mwk           = mwk;
    branch_taken  = bt;
    branch_target = tgt;
    e.pc = e_pc; e.hold = e_hold; e.bubble = e_bub; e.flush = e_flush; e.clr = e_clr;
    e.scnt = e_sc; e.fcnt = e_fc;
    sb.push_back(e);
    @(posedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("pc",     PC,           e.pc);
      checkOutput("hold",   32'(IF_ID_hold),   32'(e.hold));
      checkOutput("bubble", 32'(ID_EX_bubble), 32'(e.bubble));
      checkOutput("flush",  32'(IF_ID_flush),  32'(e.flush));
      checkOutput("clear",  32'(clear),        32'(e.clr));
`ifdef PIPE_PERF_CNT_EN
      checkOutput("stall_cnt", stall_cnt, e.scnt);
      checkOutput("flush_cnt", flush_cnt, e.fcnt);
`endif
    end
  end

  initial begin
    // rst pcd mwk bt target         pc            hold bub fl clr scnt fcnt
    applyStimulus(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'h4,        0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h0,        32'h8,        1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h0,        32'h8,        0, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'hC,        0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 32'h100,      32'h10,       0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'h100,      0, 1, 1, 1, 1, 1);
    applyStimulus(0, 1, 1, 1, 32'h40,       32'h104,      0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC, 32'h40,      0, 1, 1, 1, 1, 2);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 1, 1, 1, 3);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1, 3);
    applyStimulus(0, 1, 0, 0, 32'h0,        32'h4,        1, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 1, 1, 32'h203,      32'h4,        0, 1, 0, 0, 1, 3);
    applyStimulus(0, 0, 1, 0, 32'h0,        32'h203,      0, 1, 1, 1, 1, 4);
    applyStimulus(0, 1, 1, 0, 32'h0,        32'h207,      1, 0, 0, 0, 1, 4);

    // Now in STALL: reset between edges must clear state without waiting for a clock.
    #1;
    checkOutput("stall_bubble", 32'(ID_EX_bubble), 32'd1);
    checkOutput("stall_pc", PC, 32'h207);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("stall_cnt_pre_rst", stall_cnt, 32'd2);
`endif
    PCdelay = 1'b0;
    #1 RST = 1'b1;
    #1;
    checkOutput("async_rst_pc", PC, 32'h0);
    checkOutput("async_rst_bubble", 32'(ID_EX_bubble), 32'd0);
    checkOutput("async_rst_clear", 32'(clear), 32'd1);
    checkOutput("async_rst_hold", 32'(IF_ID_hold), 32'd0);

    applyStimulus(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 0, 0, 0);

    @(negedge CLK);
    #5;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control responder for the five-stage CPU. It consumes the load-use stall request raised by the ID-stage hazard detector and the EX-stage branch redirect. It owns the PC register and drives the hold, flush and bubble-insert controls for the IF/ID and ID/EX registers. It also drives `clear` back to the hazard detector, so the detector is neutralised while ID holds a flushed instruction.

## Interface
- `XLEN`, 32, PC and target width
- `RESET_PC`, 32'h0000_0000, PC value while and after reset
- `PC_STEP`, 4, sequential PC increment

- `CLK`  in  1  pipeline clock; all state updates on the rising edge
- `RST`  in  1  reset; one clock, asynchronous, active-high
- `PCdelay`  in  1  load-use stall request from the ID hazard detector
- `Mwk`  in  1  ID instruction-valid from the hazard detector; used only by the performance counters
- `branch_taken`  in  1  EX-stage redirect request
- `branch_target`  in  XLEN  redirect address, valid when `branch_taken`=1
- `PC`  out  XLEN  current fetch address (registered)
- `IF_ID_hold`  out  1  IF/ID register keeps its contents this cycle
- `IF_ID_flush`  out  1  IF/ID register loads a NOP on the next edge
- `ID_EX_bubble`  out  1  ID/EX register loads a NOP on the next edge
- `clear`  out  1  to the hazard detector: suppress the stall request
- `stall_cnt`  out  32  stalls taken (only with `PIPE_PERF_CNT_EN`)
- `flush_cnt`  out  32  redirects taken (only with `PIPE_PERF_CNT_EN`)

## Operation
- The FSM has three states: RUN, STALL and FLUSH.
- The next-state decision is made at each rising `CLK` edge, in strict priority order:
  1. `branch_taken`=1 (any state): PC <= `branch_target`; next state FLUSH.
  2. `PCdelay`=1 and state==RUN: PC holds; next state STALL.
  3. Otherwise: PC <= PC + `PC_STEP`, computed modulo 2^XLEN so wrap-around is silent; next state RUN.
- `PCdelay` is ignored in STALL. One bubble per load is sufficient because MEM->EX forwarding covers the rest, so back-to-back stall requests never extend a stall.
- `PCdelay` is ignored in FLUSH, because the ID instruction is being discarded.
- Output decode:
  - `IF_ID_hold` = `PCdelay` & ~`branch_taken` & (state==RUN). This is Mealy, same cycle as detection.
  - `ID_EX_bubble` = 1 in STALL or FLUSH. This is Moore.
  - `IF_ID_flush` = 1 in FLUSH.
  - `clear` = 1 in FLUSH or while `RST`=1.
- `branch_target` is not aligned by this block; bits [1:0] pass through unchanged.

## Timing
- Reset values: PC=`RESET_PC`, state=RUN, `IF_ID_hold`=0, `IF_ID_flush`=0, `ID_EX_bubble`=0, `clear`=1 while `RST` is asserted, counters=0.
- Reset takes effect immediately, including mid-STALL or mid-FLUSH.
- After `RST` deasserts, the first edge advances PC to `RESET_PC`+`PC_STEP`.
- Stall latency:
  - Detection cycle N: hold=1, PC frozen at the N+1 edge.
  - Cycle N+1: STALL, bubble=1.
  - Edge N+2: PC advances.
  - Total cost is exactly one cycle.
- Redirect latency:
  - `branch_taken` in cycle N loads PC at the N+1 edge.
  - Cycle N+1 is FLUSH, with flush, bubble and clear all asserted.
  - Cycle N+2 is RUN.
  - Total cost is exactly one cycle of killed IF/ID plus ID/EX.
- `branch_taken` and `PCdelay` asserted in the same cycle: the branch wins, hold=0, and no STALL occurs.
- `branch_taken` in STALL: the branch wins and the next state is FLUSH.
- `branch_taken` in FLUSH: the new redirect is taken and the block stays in FLUSH for another cycle.

## Configuration
- Macro: `PIPE_PERF_CNT_EN`.
- Defined:
  - `stall_cnt` increments on every RUN->STALL transition.
  - `flush_cnt` increments on every transition into FLUSH.
  - Both counters saturate at 32'hFFFF_FFFF.
  - A transition is counted only when `Mwk`=1 in the deciding cycle, or when `branch_taken`=1.
- Undefined: both ports and all counter logic are absent.

## Structure
- Package `pipe_ctrl_pkg`:
  - State enum RUN/STALL/FLUSH.
  - NOP instruction constant 32'h0000_0013.
  - `PC_STEP` default.
  - Load opcode constant 7'b0000011, shared with the hazard detector.
- Sub-module `sat_counter`:
  - 32-bit saturating counter with increment enable and asynchronous active-high reset.
  - Instantiated twice, only under `PIPE_PERF_CNT_EN`.

## Test plan
- Reset and free-run:
  - Stimulus: hold `RST`=1 for 3 cycles, then release.
  - Response: PC=0 during reset with `clear`=1; PC then runs 4, 8, 12; all controls stay 0.
- Single load-use stall:
  - Stimulus: `PCdelay`=1 for 2 cycles, starting when PC=8.
  - Response: hold=1 for one cycle; PC shows 8, 8, 12; bubble=1 exactly one cycle; `stall_cnt`=1.
- Branch redirect:
  - Stimulus: `branch_taken`=1 with target 32'h100, while PC=16.
  - Response: next PC=32'h100; flush=bubble=clear=1 for one cycle; PC then 32'h104.
- Simultaneous requests:
  - Stimulus: `PCdelay`=1 and `branch_taken`=1 with target 32'h40, in the same cycle.
  - Response: hold=0; PC=32'h40; FLUSH state; `stall_cnt` unchanged.
- Wrap-around:
  - Stimulus: branch to 32'hFFFF_FFFC.
  - Response: after the flush cycle, PC=0.
- Mid-stall reset:
  - Stimulus: assert `RST` asynchronously while in STALL.
  - Response: PC=`RESET_PC` and bubble=0 immediately, without waiting for a clock edge.
